// File: rtl/tree_frame_loader.sv
// Serial-to-parallel feature frame loader for a combinational decision tree:
// gathers one frame of bytes, lets the tree settle, then returns the class code.
module tree_frame_loader #(
  parameter int unsigned NUM_FEAT = 45,
  parameter int unsigned FEAT_W   = 8,
  parameter int unsigned CLASS_W  = 5,
  parameter int unsigned SETTLE   = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         s_valid,
  input  logic [FEAT_W-1:0]            s_data,
  input  logic                         s_last,
  output logic                         s_ready,
  output logic [NUM_FEAT*FEAT_W-1:0]   feat_bus,
  input  logic [CLASS_W-1:0]           cls_in,
  output logic                         m_valid,
  output logic [CLASS_W-1:0]           m_class,
  input  logic                         m_ready,
  output logic                         frame_err
);

  localparam int unsigned IDX_W = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
  localparam int unsigned CNT_W = $clog2(SETTLE) + 1;
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_FEAT - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {
    ST_LOAD,
    ST_SETTLE,
    ST_HOLD
  } state_t;

  state_t             state;
  logic [IDX_W-1:0]   idx;
  logic [CNT_W-1:0]   cnt;

  // s_ready is kept equal to (state == ST_LOAD) by updating it on every state change.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      idx       <= '0;
      cnt       <= '0;
      s_ready   <= 1'b1;
      feat_bus  <= '0;
      m_valid   <= 1'b0;
      m_class   <= '0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (s_valid && s_ready) begin
            feat_bus[idx*FEAT_W +: FEAT_W] <= s_data;
            if (idx == IDX_LAST) begin
              idx <= '0;
              if (s_last) begin
                state   <= ST_SETTLE;
                cnt     <= '0;
                s_ready <= 1'b0;
              end else begin
                frame_err <= 1'b1;
              end
            end else if (s_last) begin
              // Early s_last: drop the frame, leave partial bytes in place.
              idx       <= '0;
              frame_err <= 1'b1;
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        ST_SETTLE: begin
          if (cnt == CNT_LAST) begin
            m_class <= cls_in;
            m_valid <= 1'b1;
            state   <= ST_HOLD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_HOLD: begin
          if (m_valid && m_ready) begin
            m_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= ST_LOAD;
          end
        end
        default: begin
          state   <= ST_LOAD;
          s_ready <= 1'b1;
          m_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule
